// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and funct3 encodings for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - byte-enable/lane generation, load extension and access legality decode
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data,
    output logic        illegal,
    output logic        misaligned
);

    logic [31:0] lane;

    // Decode access size/sign into lanes, extension and legality
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'h0;
        load_data   = 32'h0;
        illegal     = 1'b1;
        misaligned  = 1'b0;
        lane        = mem_rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B: begin
                illegal     = 1'b0;
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {{24{lane[7]}}, lane[7:0]};
            end
            F3_H: begin
                illegal     = 1'b0;
                misaligned  = addr_lo[0];
                be          = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {{16{lane[15]}}, lane[15:0]};
            end
            F3_W: begin
                illegal     = 1'b0;
                misaligned  = |addr_lo;
                be          = 4'b1111;
                wdata_lanes = wdata;
                load_data   = lane;
            end
            F3_BU: begin
                // Unsigned sizes only exist for loads
                illegal     = is_store;
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {24'h0, lane[7:0]};
            end
            F3_HU: begin
                illegal     = is_store;
                misaligned  = addr_lo[0];
                be          = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {16'h0, lane[15:0]};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory access sequencer with req/ack memory port
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_read,
    input  logic        start_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_t       state;
    logic [2:0]       f3_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] wait_cnt;

    logic             sel_store;
    logic [2:0]       sel_f3;
    logic [1:0]       sel_addr_lo;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_c;
    logic             illegal_c;
    logic             misaligned_c;

    // The single aligner decodes the live request in IDLE and the captured one afterwards
    always_comb begin
        sel_store   = mem_we;
        sel_f3      = f3_q;
        sel_addr_lo = addr_lo_q;
        if (state == IDLE) begin
            sel_store   = start_write;
            sel_f3      = funct3;
            sel_addr_lo = addr[1:0];
        end
    end

    lsu_align u_align (
        .is_store    (sel_store),
        .funct3      (sel_f3),
        .addr_lo     (sel_addr_lo),
        .wdata       (wdata),
        .mem_rdata   (mem_rdata),
        .be          (be_c),
        .wdata_lanes (wdata_c),
        .load_data   (load_c),
        .illegal     (illegal_c),
        .misaligned  (misaligned_c)
    );

    // Access FSM with wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            f3_q      <= 3'b000;
            addr_lo_q <= 2'b00;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_write || start_read) begin
                        // start_write wins, so a simultaneous read is simply dropped
                        f3_q      <= funct3;
                        addr_lo_q <= addr[1:0];
                        mem_we    <= start_write;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                        wait_cnt  <= '0;
                        busy      <= 1'b1;
                        if (illegal_c || misaligned_c) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (!mem_we) begin
                            rdata <= load_c;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ERR;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a transaction-level model
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read;
    logic        start_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_read  (start_read),
        .start_write (start_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle
    bit          chk_en  = 1'b0;
    bit          chk_mem = 1'b0;
    logic        e_busy, e_done, e_err, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [31:0] model_rdata;

    // Observations kept by the compare process
    int          req_total     = 0;
    int          last_done_cyc = 0;
    logic        last_err      = 1'b0;
    logic [3:0]  seen_be       = 4'h0;
    logic [31:0] seen_addr     = 32'h0;
    logic [31:0] seen_wdata    = 32'h0;

    int start_cyc;
    int req_mark;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(busy),    32'(e_busy));
            check("done",    32'(done),    32'(e_done));
            check("err",     32'(err),     32'(e_err));
            check("mem_req", 32'(mem_req), 32'(e_req));
            check("rdata",   rdata,        e_rdata);
            if (chk_mem) begin
                check("mem_we",    32'(mem_we), 32'(e_we));
                check("mem_addr",  mem_addr,    e_addr);
                check("mem_be",    32'(mem_be), 32'(e_be));
                check("mem_wdata", mem_wdata,   e_wdata);
            end
            if (mem_req) begin
                req_total++;
                seen_be    = mem_be;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (done) begin
                last_done_cyc = cyc;
                last_err      = err;
            end
        end
    end

    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_bad(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % m_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] mask;
        mask = 4'((1 << m_bytes(f3)) - 1);
        return 4'(mask << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int b;
        b = m_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % b) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        logic [31:0] t;
        int sh;
        sh = 32 - 8 * m_bytes(f3);
        t  = (rw >> (8 * a[1:0])) << sh;
        if (f3[2]) return t >> sh;
        return $signed(t) >>> sh;
    endfunction

    task automatic set_idle_exp();
        chk_mem = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_req   = 1'b0;
        e_rdata = model_rdata;
    endtask

    task automatic set_reset_exp();
        model_rdata = 32'h0;
        set_idle_exp();
        chk_mem = 1'b1;
        e_we    = 1'b0;
        e_addr  = 32'h0;
        e_be    = 4'h0;
        e_wdata = 32'h0;
    endtask

    task automatic busy_noise();
        start_read  = ($urandom % 4) == 0;
        start_write = ($urandom % 4) == 0;
        funct3      = 3'($urandom);
        addr        = $urandom;
        wdata       = $urandom;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        start_read  = 1'b0;
        start_write = 1'b0;
        mem_ack     = 1'b0;
    endtask

    task automatic idle_cycle();
        set_idle_exp();
        mem_ack   = 1'($urandom % 2);
        mem_rdata = $urandom;
        end_cycle();
    endtask

    task automatic do_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int waits, input logic [31:0] rw,
                             input int rst_at);
        bit acked;
        bit tmo;
        set_idle_exp();
        start_write = wr;
        start_read  = wr ? 1'($urandom % 2) : 1'b1;
        funct3      = f3;
        addr        = a;
        wdata       = wd;
        mem_ack     = 1'($urandom % 2);
        mem_rdata   = $urandom;
        start_cyc   = cyc;
        req_mark    = req_total;
        @(posedge clk);
        #1;
        busy_noise();
        if (m_bad(wr, f3, a)) begin
            chk_mem = 1'b0;
            e_busy  = 1'b1;
            e_done  = 1'b1;
            e_err   = 1'b1;
            e_req   = 1'b0;
            mem_ack = 1'($urandom % 2);
            end_cycle();
            return;
        end
        acked = 1'b0;
        tmo   = 1'b0;
        for (int i = 0; !acked && !tmo; i++) begin
            chk_mem = 1'b1;
            e_busy  = 1'b1;
            e_done  = 1'b0;
            e_err   = 1'b0;
            e_req   = 1'b1;
            e_we    = wr;
            e_addr  = {a[31:2], 2'b00};
            e_be    = m_be(f3, a);
            e_wdata = m_wdata(f3, wd);
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rw;
                acked     = 1'b1;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (i == rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                reset       = 1'b0;
                start_read  = 1'b0;
                start_write = 1'b0;
                mem_ack     = 1'b0;
                set_reset_exp();
                end_cycle();
                return;
            end
            busy_noise();
            if (!acked && i == T - 1) tmo = 1'b1;
        end
        if (acked && !wr) model_rdata = m_ext(f3, a, rw);
        chk_mem = 1'b0;
        e_busy  = 1'b1;
        e_done  = 1'b1;
        e_err   = tmo;
        e_req   = 1'b0;
        e_rdata = model_rdata;
        mem_ack = 1'($urandom % 2);
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        reset       = 1'b1;
        start_read  = 1'b0;
        start_write = 1'b0;
        funct3      = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        model_rdata = 32'h0;
        @(posedge clk);
        #1;
        set_reset_exp();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // SW, zero-wait memory
        do_access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 32'h0, -1);
        check("sw_be",      32'(seen_be), 32'h0000000F);
        check("sw_addr",    seen_addr,    32'h00000104);
        check("sw_wdata",   seen_wdata,   32'hDEADBEEF);
        check("sw_latency", 32'(last_done_cyc - start_cyc), 32'd2);
        check("sw_err",     32'(last_err), 32'd0);

        // SB to the top lane
        do_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0, -1);
        check("sb_be",    32'(seen_be), 32'h00000008);
        check("sb_wdata", seen_wdata,   32'hA5A5A5A5);
        check("sb_addr",  seen_addr,    32'h00000100);

        // LB / LBU after three wait cycles
        do_access(1'b0, 3'b000, 32'h102, 32'h0, 3, 32'h12F05678, -1);
        check("lb_rdata", rdata, 32'hFFFFFFF0);
        do_access(1'b0, 3'b100, 32'h102, 32'h0, 3, 32'h12F05678, -1);
        check("lbu_rdata", rdata, 32'h000000F0);

        // Misaligned LH
        do_access(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, -1);
        check("lh_mis_req",     32'(req_total - req_mark), 32'd0);
        check("lh_mis_latency", 32'(last_done_cyc - start_cyc), 32'd1);
        check("lh_mis_err",     32'(last_err), 32'd1);
        check("lh_mis_rdata",   rdata, 32'h000000F0);

        // LW with no ack
        do_access(1'b0, 3'b010, 32'h108, 32'h0, 99, 32'h0, -1);
        check("tmo_req_cycles", 32'(req_total - req_mark), 32'd4);
        check("tmo_err",        32'(last_err), 32'd1);
        check("tmo_latency",    32'(last_done_cyc - start_cyc), 32'd5);

        // Reset during the second REQ cycle
        do_access(1'b0, 3'b010, 32'h200, 32'h0, 99, 32'h0, 1);
        check("rst_rdata", rdata, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom % 2);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            if (($urandom % 5) == 0) idle_cycle();
            do_access(wr, f3, a, $urandom, $urandom_range(0, T + 1), $urandom,
                      (($urandom % 25) == 0) ? 0 : -1);
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
